sseg_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between several requesters. Each requester raises a request with a 16-bit, four-nibble value. The block grants the display to one requester at a time, round-robin, for a minimum number of refresh ticks. It drives the `digit0`..`digit3` inputs of the display top level, and its `tick` input comes from the same refresh-overflow strobe that enables the display scanner.

---
 rtl/sseg_arb_pkg.sv | 20 ++
 rtl/sseg_arbiter_rr_pick.sv | 34 +++
 rtl/sseg_arbiter.sv | 137 +++++++++++++
 tb/tb_sseg_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_arb_pkg.sv
// Shared types for the seven-segment display arbiter: FSM states, digit
// bundle type and digit geometry.
package sseg_arb_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sseg_arb_state_e;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sseg_val_t;

  // Element 0 of the bundle is the least significant nibble (digit0).
  function automatic sseg_val_t to_sseg_val(input logic [NUM_DIGITS*DIGIT_W-1:0] raw);
    return sseg_val_t'(raw);
  endfunction

endpackage

// File: rtl/sseg_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request starting one
// past the previous owner, wrapping around to the previous owner last.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [NUM_REQ-1:0][IDX_W-1:0] cand_idx;
  logic [NUM_REQ-1:0]            cand_hit;

  // Candidate gi is the requester gi+1 places after the previous owner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(last) + gi + 1) % NUM_REQ);
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  // Walk from the farthest candidate down so the nearest hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        winner = cand_idx[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_arbiter.sv
// Round-robin sharing of the 4-digit seven-segment display between requesters.
// Optional SSEG_ARB_OWNER_EN: digit3 shows the owner index instead of req_data[15:12].
module sseg_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int HOLD_TICKS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0][15:0]  req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [3:0]                digit0,
  output logic [3:0]                digit1,
  output logic [3:0]                digit2,
  output logic [3:0]                digit3
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]   HOLD_MAX = CNT_W'(HOLD_TICKS);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);

  sseg_arb_state_e     state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic                busy_reg, busy_next;
  logic [IDX_W-1:0]    last_reg, last_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  sseg_val_t           digits_reg, digits_next;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                rival;
  logic                hold_done;
  sseg_val_t           win_val;
  sseg_val_t           own_val;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last_reg),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // last_reg is the current owner while granted, so the search finds it only
  // after every other requester; a different winner means someone is waiting.
  assign rival     = pick_valid && (pick_idx != last_reg);
  assign hold_done = (cnt_reg == HOLD_MAX);

  always_comb begin
    win_val = to_sseg_val(req_data[pick_idx]);
    own_val = to_sseg_val(req_data[last_reg]);
`ifdef SSEG_ARB_OWNER_EN
    win_val[NUM_DIGITS-1] = DIGIT_W'(pick_idx);
    own_val[NUM_DIGITS-1] = DIGIT_W'(last_reg);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      busy_reg   <= 1'b0;
      last_reg   <= LAST_RST;
      cnt_reg    <= '0;
      digits_reg <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      busy_reg   <= busy_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      digits_reg <= digits_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    digits_next = digits_reg;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next  = GRANT;
          gnt_next    = GNT_ONE << pick_idx;
          last_next   = pick_idx;
          cnt_next    = '0;
          digits_next = win_val;
        end
      end
      GRANT: begin
        // An owner drop beats a rotation tick; the waiting requester is
        // picked up from IDLE on the following edge.
        if (!req[last_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else if (tick) begin
          if (hold_done && rival) begin
            gnt_next    = GNT_ONE << pick_idx;
            last_next   = pick_idx;
            cnt_next    = '0;
            digits_next = win_val;
          end else begin
            digits_next = own_val;
            if (!hold_done) begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    busy_next = |gnt_next;
  end

  assign gnt    = gnt_reg;
  assign busy   = busy_reg;
  assign digit0 = digits_reg[0];
  assign digit1 = digits_reg[1];
  assign digit2 = digits_reg[2];
  assign digit3 = digits_reg[3];

endmodule

// File: tb/tb_sseg_arbiter.sv
// Directed and randomized bench for sseg_arbiter against a behavioural
// owner/hold model evaluated once per clock.
module tb_sseg_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int HOLD_TICKS = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     tick;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][15:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [3:0]               digit0, digit1, digit2, digit3;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), previous owner, hold ticks.
  int          m_owner;
  int          m_last;
  int          m_cnt;
  logic [15:0] m_dig;

  sseg_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3)
  );

  always #5 clk = ~clk;

  function automatic int m_pick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (m_last + k) % NUM_REQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_load(input int w);
    logic [15:0] v;
    v = req_data[w];
`ifdef SSEG_ARB_OWNER_EN
    v[15:12] = 4'(w);
`endif
    return v;
  endfunction

  task automatic m_step();
    int w;
    if (rst) begin
      m_owner = -1;
      m_last  = NUM_REQ - 1;
      m_cnt   = 0;
      m_dig   = 16'h0000;
    end else if (m_owner < 0) begin
      w = m_pick();
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
        m_dig   = m_load(w);
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (tick) begin
      w = m_pick();
      if (m_cnt == HOLD_TICKS && w >= 0 && w != m_owner) begin
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
        m_dig   = m_load(w);
      end else begin
        m_dig = m_load(m_owner);
        if (m_cnt < HOLD_TICKS) m_cnt++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NUM_REQ-1:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? '0 : NUM_REQ'(1) << m_owner;
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    check({tag, ".digits"}, 32'({digit3, digit2, digit1, digit0}), 32'(m_dig));
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    m_step();
    check_model(tag);
  endtask

  initial begin
    logic [15:0] exp_ff;
    m_owner  = -1;
    m_last   = NUM_REQ - 1;
    m_cnt    = 0;
    m_dig    = '0;
    rst      = 1'b1;
    tick     = 1'b0;
    req      = '0;
    req_data = '0;

    // Reset with requests already up: they must be ignored during reset.
    req         = 3'b011;
    req_data[0] = 16'h1234;
    req_data[1] = 16'hABCD;
    cycle("reset");
    cycle("reset");
    check("reset.gnt", 32'(gnt), 32'h0);
    check("reset.digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    $display("step reset: gnt=%b busy=%b", gnt, busy);

    rst = 1'b0;
    cycle("first_grant");
    check("first_grant.gnt", 32'(gnt), 32'h1);
    check("first_grant.digits", 32'({digit2, digit1, digit0}), 32'h234);
    $display("step first grant: gnt=%b digits=%h%h%h%h", gnt, digit3, digit2, digit1, digit0);

    // Rotation every HOLD_TICKS+1 ticks with both requesters held high.
    for (int t = 1; t <= 10; t++) begin
      repeat (7) cycle("rotate_gap");
      tick = 1'b1;
      cycle("rotate_tick");
      tick = 1'b0;
      if (t == 4) check("rotate.t4", 32'(gnt), 32'h1);
      if (t == 5) check("rotate.t5", 32'(gnt), 32'h2);
      if (t == 9) check("rotate.t9", 32'(gnt), 32'h2);
      if (t == 10) check("rotate.t10", 32'(gnt), 32'h1);
      $display("step rotate tick %0d: gnt=%b", t, gnt);
    end

    // Data change between ticks is deferred to the next tick.
    req         = 3'b001;
    req_data[0] = 16'h0001;
    tick        = 1'b1;
    cycle("tear_load");
    tick        = 1'b0;
    req_data[0] = 16'h0002;
    repeat (3) cycle("tear_hold");
    check("tear.hold", 32'({digit3, digit2, digit1, digit0}), 32'h0001);
    tick = 1'b1;
    cycle("tear_tick");
    tick = 1'b0;
    check("tear.update", 32'({digit3, digit2, digit1, digit0}), 32'h0002);
    $display("step no-tearing: digits=%h%h%h%h", digit3, digit2, digit1, digit0);

    // Expire the hold, then drop the owner on a tick with requester 2 waiting.
    repeat (5) begin
      tick = 1'b1;
      cycle("expire_tick");
      tick = 1'b0;
      cycle("expire_gap");
    end
    req  = 3'b100;
    tick = 1'b1;
    cycle("drop_tick");
    tick = 1'b0;
    check("drop.idle", 32'(gnt), 32'h0);
    cycle("drop_regrant");
    check("drop.regrant", 32'(gnt), 32'h4);
    $display("step drop vs rotate: gnt=%b", gnt);

    // Reset mid-grant, then everyone requests: requester 0 wins.
    rst = 1'b1;
    cycle("midreset");
    check("midreset.gnt", 32'(gnt), 32'h0);
    check("midreset.busy", 32'(busy), 32'h0);
    check("midreset.digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    rst = 1'b0;
    req = 3'b111;
    cycle("after_reset");
    check("after_reset.gnt", 32'(gnt), 32'h1);
    $display("step mid-grant reset: gnt=%b", gnt);

    // Requester 2 with all-ones data.
    req = 3'b000;
    cycle("release");
    req_data[2] = 16'hFFFF;
    req         = 3'b100;
    cycle("owner_digit");
`ifdef SSEG_ARB_OWNER_EN
    exp_ff = 16'h2FFF;
`else
    exp_ff = 16'hFFFF;
`endif
    check("owner_digit.gnt", 32'(gnt), 32'h4);
    check("owner_digit.digits", 32'({digit3, digit2, digit1, digit0}), 32'(exp_ff));
    $display("step owner digit: digits=%h%h%h%h", digit3, digit2, digit1, digit0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 12) req = NUM_REQ'($urandom);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 3) req_data[$urandom_range(0, NUM_REQ - 1)] = 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle("random");
    end
    rst = 1'b0;
    $display("step random traffic: done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
